// File: rtl/riscv_modq_pkg.sv
// Shared decode constants and state encodings for the modular-arithmetic coprocessor.
package riscv_modq_pkg;

    localparam logic [6:0] OPCODE_MODQ = 7'h0B;
    localparam logic [6:0] FUNCT7_MODQ = 7'h01;

    typedef enum logic [2:0] {
        F3_ADDMOD = 3'b000,
        F3_SUBMOD = 3'b001,
        F3_MULQ   = 3'b010,
        F3_SETQ   = 3'b011,
        F3_GETQ   = 3'b100
    } modq_func3_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } modq_state_e;

endpackage

// File: rtl/modq_mul_seq.sv
// Bit-serial interleaved modular multiplier: one bit of b per cycle, MSB first.
module modq_mul_seq
    import riscv_modq_pkg::*;
#(
    parameter int unsigned QW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [QW-1:0] a,
    input  logic [QW-1:0] b,
    input  logic [QW-1:0] q,
    output logic          done,
    output logic [QW-1:0] p
);

    localparam int unsigned CW = $clog2(QW);

    logic [QW-1:0] a_r, b_r, q_r, acc;
    logic [CW-1:0] cnt;
    logic          run;
    logic [QW:0]   dbl, r1, sum, qx;

    // Each step keeps acc < q, so the QW+1-bit intermediates never overflow.
    always_comb begin
        qx  = {1'b0, q_r};
        dbl = {acc, 1'b0};
        r1  = (dbl >= qx) ? dbl - qx : dbl;
        sum = r1 + (b_r[cnt] ? {1'b0, a_r} : '0);
        p   = (sum >= qx) ? QW'(sum - qx) : sum[QW-1:0];
    end

    // done flags the cycle in which the final bit is folded in; p is valid then.
    assign done = run && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            a_r <= '0;
            b_r <= '0;
            q_r <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(QW - 1);
            acc <= '0;
            a_r <= a;
            b_r <= b;
            q_r <= q;
        end else if (run) begin
            acc <= p;
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/riscv_modq_unit.sv
// Custom-0 modular arithmetic unit: ADDMOD/SUBMOD/MULQ over a programmable modulus q.
module riscv_modq_unit
    import riscv_modq_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned QW        = 16,
    parameter int unsigned Q_DEFAULT = 3329
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            wr,
    output logic [XLEN-1:0] rd,
    output logic            busy,
    output logic            ready
);

    modq_state_e   state_q, state_d;
    modq_func3_e   f3;
    logic          hit, accept, legal, setq_ok;
    logic [QW-1:0] q_r, a, b, res, mul_p;
    logic [QW:0]   qx, s, d;
    logic          mul_done;
    logic [XLEN-1:0] rd_r;
    logic          wr_r;
    logic          unused_bits;

    assign f3      = modq_func3_e'(instruction[14:12]);
    assign hit     = valid && (instruction[6:0] == OPCODE_MODQ) && (instruction[31:25] == FUNCT7_MODQ);
    assign accept  = hit && (state_q == IDLE);
    assign a       = rs1[QW-1:0];
    assign b       = rs2[QW-1:0];
    assign setq_ok = (rs1[XLEN-1:QW] == '0) && (rs1[QW-1:0] >= QW'(2));
    assign unused_bits = ^{instruction[24:15], instruction[11:7], rs2[XLEN-1:QW]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (f3 == F3_MULQ) ? MUL : RESP;
            MUL:     if (mul_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        ready = (state_q == RESP);
        wr    = ready && wr_r;
        rd    = rd_r;
    end

    // Single-cycle ops resolve at the accept edge straight from rs1/rs2.
    always_comb begin
        qx    = {1'b0, q_r};
        s     = {1'b0, a} + {1'b0, b};
        d     = {1'b0, a} - {1'b0, b};
        res   = '0;
        legal = 1'b1;
        case (f3)
            F3_ADDMOD: res = (s >= qx) ? QW'(s - qx) : s[QW-1:0];
            F3_SUBMOD: res = d[QW] ? QW'(d + qx) : d[QW-1:0];
            F3_MULQ:   res = '0;
            F3_SETQ:   res = setq_ok ? q_r : '0;
            F3_GETQ:   res = q_r;
            default:   legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r  <= QW'(Q_DEFAULT);
            rd_r <= '0;
            wr_r <= 1'b0;
        end else if (accept) begin
            wr_r <= legal;
            if (f3 != F3_MULQ) rd_r <= {{(XLEN-QW){1'b0}}, res};
            if (f3 == F3_SETQ && setq_ok) q_r <= rs1[QW-1:0];
        end else if (state_q == MUL && mul_done) begin
            rd_r <= {{(XLEN-QW){1'b0}}, mul_p};
        end
    end

    modq_mul_seq #(.QW(QW)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (accept && (f3 == F3_MULQ)),
        .a     (a),
        .b     (b),
        .q     (q_r),
        .done  (mul_done),
        .p     (mul_p)
    );

endmodule

// File: tb/tb_riscv_modq_unit.sv
// Directed self-checking bench for riscv_modq_unit with hand-computed expectations.
module tb_riscv_modq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] rs1, rs2;
    logic        wr, busy, ready;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_modq_unit #(.XLEN(32), .QW(16), .Q_DEFAULT(3329)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .instruction (instruction),
        .rs1         (rs1),
        .rs2         (rs2),
        .wr          (wr),
        .rd          (rd),
        .busy        (busy),
        .ready       (ready)
    );

    function automatic logic [31:0] mk_instr(input logic [2:0] f3);
        return {7'h01, 10'b0, f3, 5'b0, 7'h0B};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for ready, check latency, busy cycles, rd and wr.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd, input logic exp_wr,
                          input int exp_lat, input bit inject);
        int lat;
        int busy_cnt;
        @(negedge clk);
        valid = 1'b1; instruction = mk_instr(f3); rs1 = a; rs2 = b;
        @(negedge clk);
        valid = 1'b0; rs1 = '0; rs2 = '0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!ready && lat < 40) begin
            if (inject && lat == 5) begin
                valid = 1'b1; instruction = mk_instr(3'b000); rs1 = 32'd7; rs2 = 32'd9;
            end
            @(negedge clk);
            valid = 1'b0;
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_cnt, exp_lat);
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_wr"}, {31'b0, wr}, {31'b0, exp_wr});
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; instruction = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("rst_rd", rd, 0);
        check("rst_wr", {31'b0, wr}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, ready}, 0);
        reset = 1'b0;

        run_op("add_wrap",  3'b000, 3328, 1,    0,    1'b1, 1, 1'b0);
        run_op("sub_neg",   3'b001, 0,    1,    3328, 1'b1, 1, 1'b0);
        run_op("sub_zero",  3'b001, 5,    5,    0,    1'b1, 1, 1'b0);
        run_op("add_max",   3'b000, 1664, 1664, 3328, 1'b1, 1, 1'b0);
        run_op("add_wrap2", 3'b000, 1000, 2000, 3000, 1'b1, 1, 1'b0);
        run_op("mul_m1sq",  3'b010, 3328, 3328, 1,    1'b1, 17, 1'b1);
        run_op("mul_gen",   3'b010, 1234, 2000, 1211, 1'b1, 17, 1'b0);
        run_op("bad_f3",    3'b101, 11,   22,   0,    1'b0, 1, 1'b0);
        run_op("setq17",    3'b011, 17,   0,    3329, 1'b1, 1, 1'b0);
        run_op("mul_q17",   3'b010, 5,    7,    1,    1'b1, 17, 1'b0);
        run_op("setq_1",    3'b011, 1,    0,    0,    1'b1, 1, 1'b0);
        run_op("setq_big",  3'b011, 65536, 0,   0,    1'b1, 1, 1'b0);
        run_op("getq",      3'b100, 0,    0,    17,   1'b1, 1, 1'b0);
        run_op("sub_q17",   3'b001, 3,    10,   10,   1'b1, 1, 1'b0);

        // Foreign opcode must be ignored entirely.
        @(negedge clk);
        valid = 1'b1; instruction = 32'h0000_0033; rs1 = 32'd1; rs2 = 32'd2;
        @(negedge clk);
        valid = 1'b0;
        check("foreign_busy", {31'b0, busy}, 0);
        check("foreign_ready", {31'b0, ready}, 0);
        check("foreign_rd_hold", rd, 10);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        valid = 1'b1; instruction = mk_instr(3'b010); rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 1);
        reset = 1'b1;
        #1;
        check("abort_rd", rd, 0);
        check("abort_wr", {31'b0, wr}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_ready", {31'b0, ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("abort_no_ready", {31'b0, ready}, 0);
        end
        run_op("getq_rst", 3'b100, 0, 0, 3329, 1'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
